aexm_ibuf: RTL and testbench

AEXM_IBUF -- requirements
Module: aexm_ibuf

---
 rtl/aexm_ibuf.sv | 146 ++++++++++++++
 tb/tb_aexm_ibuf.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/aexm_ibuf.sv
// Instruction fetch buffer: a two-entry FIFO between the instruction cache and
// the decode register, with barrel-shift stall bubbles, branch flush and IMM prefix capture.
//
// state    | meaning
// RUN      | normal decode: pop, bypass or underflow bubble
// BSF_HOLD | second bubble of a barrel-shift stall
module aexm_ibuf #(
  parameter logic [31:0] NOP = 32'h80000000
) (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic [31:0] iwb_dat_i,
  input  logic        iwb_ack_i,
  output logic        iwb_rdy_o,
  input  logic        d_en,
  input  logic        fSTALL,
  input  logic        xBRANCH,
  output logic [31:0] dINST,
  output logic        dVALID,
  output logic [31:0] dSIMM
);

  typedef enum logic {RUN = 1'b0, BSF_HOLD = 1'b1} state_t;

  localparam logic [5:0] IMM_OP = 6'o54;

  state_t      r_state;
  logic [31:0] r_mem [0:1];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;
  logic [31:0] r_dinst;
  logic        r_dvalid;
  logic [15:0] r_immh;
  logic        r_immv;

  state_t      w_state_nxt;
  logic        w_rd_ptr_nxt;
  logic        w_wr_ptr_nxt;
  logic [1:0]  w_count_nxt;
  logic [31:0] w_dinst_nxt;
  logic        w_dvalid_nxt;
  logic [15:0] w_immh_nxt;
  logic        w_immv_nxt;
  logic        w_push;
  logic        w_mem_we;
  logic        w_pop;
  logic        w_is_imm;

  assign iwb_rdy_o = (r_count < 2'd2);
  assign w_push    = iwb_ack_i && iwb_rdy_o;
  assign w_is_imm  = r_dvalid && (r_dinst[31:26] == IMM_OP);

  always_comb begin
    w_state_nxt  = r_state;
    w_dinst_nxt  = r_dinst;
    w_dvalid_nxt = r_dvalid;
    w_immh_nxt   = r_immh;
    w_immv_nxt   = r_immv;
    w_mem_we     = w_push;
    w_pop        = 1'b0;

    if (d_en) begin
      // The instruction leaving dINST decides whether the prefix stays armed.
      if (r_dvalid) begin
        w_immv_nxt = w_is_imm;
        if (w_is_imm) w_immh_nxt = r_dinst[15:0];
      end
      case (r_state)
        RUN: begin
          if (fSTALL) begin
            w_state_nxt  = BSF_HOLD;
            w_dinst_nxt  = NOP;
            w_dvalid_nxt = 1'b0;
          end else if (r_count != 2'd0) begin
            w_pop        = 1'b1;
            w_dinst_nxt  = r_mem[r_rd_ptr];
            w_dvalid_nxt = 1'b1;
          end else if (w_push) begin
            w_mem_we     = 1'b0;
            w_dinst_nxt  = iwb_dat_i;
            w_dvalid_nxt = 1'b1;
          end else begin
            w_dinst_nxt  = NOP;
            w_dvalid_nxt = 1'b0;
          end
        end
        BSF_HOLD: begin
          w_state_nxt  = RUN;
          w_dinst_nxt  = NOP;
          w_dvalid_nxt = 1'b0;
        end
        default: w_state_nxt = RUN;
      endcase
    end

    w_wr_ptr_nxt = r_wr_ptr ^ w_mem_we;
    w_rd_ptr_nxt = r_rd_ptr ^ w_pop;
    w_count_nxt  = r_count + {1'b0, w_mem_we} - {1'b0, w_pop};

    // Branch flush discards everything fetched, including a word arriving now.
    if (d_en && xBRANCH) begin
      w_state_nxt  = RUN;
      w_dinst_nxt  = NOP;
      w_dvalid_nxt = 1'b0;
      w_immh_nxt   = 16'h0;
      w_immv_nxt   = 1'b0;
      w_mem_we     = 1'b0;
      w_pop        = 1'b0;
      w_wr_ptr_nxt = 1'b0;
      w_rd_ptr_nxt = 1'b0;
      w_count_nxt  = 2'd0;
    end
  end

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      r_state  <= RUN;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_dinst  <= NOP;
      r_dvalid <= 1'b0;
      r_immh   <= 16'h0;
      r_immv   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
      r_dinst  <= w_dinst_nxt;
      r_dvalid <= w_dvalid_nxt;
      r_immh   <= w_immh_nxt;
      r_immv   <= w_immv_nxt;
    end
  end

  always_ff @(posedge gclk) begin
    if (grst_n && w_mem_we) r_mem[r_wr_ptr] <= iwb_dat_i;
  end

  assign dINST  = r_dinst;
  assign dVALID = r_dvalid;
  assign dSIMM  = r_immv ? {r_immh, r_dinst[15:0]} : {{16{r_dinst[15]}}, r_dinst[15:0]};

endmodule

// File: tb/tb_aexm_ibuf.sv
// Bench for aexm_ibuf: a queue-based model checked every cycle, plus directed
// vectors with literal expectations for the key scenarios.
module tb_aexm_ibuf;

  localparam logic [31:0] NOP = 32'h80000000;

  logic        gclk = 1'b0;
  logic        grst_n = 1'b0;
  logic [31:0] iwb_dat_i = 32'h0;
  logic        iwb_ack_i = 1'b0;
  logic        iwb_rdy_o;
  logic        d_en = 1'b0;
  logic        fSTALL = 1'b0;
  logic        xBRANCH = 1'b0;
  logic [31:0] dINST;
  logic        dVALID;
  logic [31:0] dSIMM;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  aexm_ibuf #(.NOP(NOP)) dut (
    .gclk(gclk), .grst_n(grst_n), .iwb_dat_i(iwb_dat_i), .iwb_ack_i(iwb_ack_i),
    .iwb_rdy_o(iwb_rdy_o), .d_en(d_en), .fSTALL(fSTALL), .xBRANCH(xBRANCH),
    .dINST(dINST), .dVALID(dVALID), .dSIMM(dSIMM)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: fetched words as a queue; a pending-bubble flag for the shift stall.
  logic [31:0] mq[$];
  bit          m_second_bubble = 1'b0;
  logic [31:0] m_inst = NOP;
  bit          m_valid = 1'b0;
  logic [15:0] m_immh = 16'h0;
  bit          m_immv = 1'b0;

  always @(posedge gclk) begin
    bit accept;
    accept = iwb_ack_i && (mq.size() < 2);
    if (!grst_n) begin
      mq.delete();
      m_second_bubble = 1'b0;
      m_inst = NOP; m_valid = 1'b0; m_immh = 16'h0; m_immv = 1'b0;
    end else if (d_en && xBRANCH) begin
      mq.delete();
      m_second_bubble = 1'b0;
      m_inst = NOP; m_valid = 1'b0; m_immh = 16'h0; m_immv = 1'b0;
    end else if (d_en) begin
      if (m_valid) begin
        if (m_inst[31:26] == 6'b101100) begin
          m_immh = m_inst[15:0];
          m_immv = 1'b1;
        end else begin
          m_immv = 1'b0;
        end
      end
      if (accept) mq.push_back(iwb_dat_i);
      if (m_second_bubble || fSTALL) begin
        m_second_bubble = !m_second_bubble;
        m_inst = NOP; m_valid = 1'b0;
      end else if (mq.size() > 0) begin
        m_inst = mq.pop_front(); m_valid = 1'b1;
      end else begin
        m_inst = NOP; m_valid = 1'b0;
      end
    end else if (accept) begin
      mq.push_back(iwb_dat_i);
    end
  end

  always @(negedge gclk) begin
    if (chk_en) begin
      chk("model_dINST", dINST, m_inst);
      chk("model_dVALID", {31'h0, dVALID}, {31'h0, m_valid});
      chk("model_rdy", {31'h0, iwb_rdy_o}, {31'h0, mq.size() < 2});
      chk("model_dSIMM", dSIMM,
          m_immv ? {m_immh, m_inst[15:0]} : {{16{m_inst[15]}}, m_inst[15:0]});
    end
  end

  task automatic cyc(input bit rst_n, input bit ack, input logic [31:0] dat,
                     input bit den, input bit stall, input bit br);
    grst_n = rst_n; iwb_ack_i = ack; iwb_dat_i = dat;
    d_en = den; fSTALL = stall; xBRANCH = br;
    @(posedge gclk);
    #1;
  endtask

  initial begin
    // Reset with competing push, stall and flush requests.
    cyc(0, 1, 32'hDEAD0001, 1, 1, 0);
    chk_en = 1'b1;
    cyc(0, 1, 32'hDEAD0002, 1, 0, 1);
    chk("rst_dINST", dINST, NOP);
    chk("rst_dVALID", {31'h0, dVALID}, 32'h0);
    chk("rst_rdy", {31'h0, iwb_rdy_o}, 32'h1);

    // Two pushes while decode is held, then two pops in order.
    cyc(1, 1, 32'hA0000001, 0, 0, 0);
    cyc(1, 1, 32'hA0000002, 0, 0, 0);
    chk("fill_rdy", {31'h0, iwb_rdy_o}, 32'h0);
    cyc(1, 0, 32'h0, 1, 0, 0);
    chk("pop1", dINST, 32'hA0000001);
    chk("pop1_rdy", {31'h0, iwb_rdy_o}, 32'h1);
    cyc(1, 0, 32'h0, 1, 0, 0);
    chk("pop2", dINST, 32'hA0000002);
    chk("pop2_valid", {31'h0, dVALID}, 32'h1);

    // Bypass on empty, then underflow bubble.
    cyc(1, 1, 32'h30600005, 1, 0, 0);
    chk("bypass", dINST, 32'h30600005);
    chk("bypass_rdy", {31'h0, iwb_rdy_o}, 32'h1);
    cyc(1, 0, 32'h0, 1, 0, 0);
    chk("underflow", dINST, NOP);
    chk("underflow_valid", {31'h0, dVALID}, 32'h0);

    // IMM prefix extends the next immediate only.
    cyc(1, 1, 32'hB0001234, 1, 0, 0);
    cyc(1, 1, 32'h2020FFFF, 1, 0, 0);
    chk("imm_simm", dSIMM, 32'h1234FFFF);
    cyc(1, 1, 32'h2020FFFF, 1, 0, 0);
    chk("imm_cleared", dSIMM, 32'hFFFFFFFF);
    cyc(1, 0, 32'h0, 1, 0, 0);
    chk("nop_simm", dSIMM, 32'h0);

    // Barrel-shift stall at count=2: two bubbles, then in-order pops.
    cyc(1, 1, 32'hC0000001, 0, 0, 0);
    cyc(1, 1, 32'hC0000002, 0, 0, 0);
    cyc(1, 0, 32'h0, 1, 1, 0);
    chk("bsf1_valid", {31'h0, dVALID}, 32'h0);
    chk("bsf1_rdy", {31'h0, iwb_rdy_o}, 32'h0);
    cyc(1, 0, 32'h0, 1, 0, 0);
    chk("bsf2_inst", dINST, NOP);
    chk("bsf2_rdy", {31'h0, iwb_rdy_o}, 32'h0);
    cyc(1, 0, 32'h0, 1, 0, 0);
    chk("bsf_pop1", dINST, 32'hC0000001);
    cyc(1, 1, 32'hC0000003, 1, 0, 0);
    chk("pushpop_c2", dINST, 32'hC0000002);
    cyc(1, 0, 32'h0, 1, 0, 0);
    chk("pushpop_c3", dINST, 32'hC0000003);

    // A pop at count=2 does not open the buffer to a same-cycle push.
    cyc(1, 1, 32'hD0000001, 0, 0, 0);
    cyc(1, 1, 32'hD0000002, 0, 0, 0);
    cyc(1, 1, 32'hD0000003, 1, 0, 0);
    chk("full_pop_d1", dINST, 32'hD0000001);
    cyc(1, 0, 32'h0, 1, 0, 0);
    chk("full_pop_d2", dINST, 32'hD0000002);
    cyc(1, 0, 32'h0, 1, 0, 0);
    chk("d3_dropped", {31'h0, dVALID}, 32'h0);

    // Flush at count=2 with a same-cycle push and an armed IMM.
    cyc(1, 1, 32'hB000ABCD, 1, 0, 0);
    cyc(1, 1, 32'hE0000001, 0, 0, 0);
    cyc(1, 1, 32'hE0000002, 0, 0, 0);
    cyc(1, 1, 32'hF0000001, 1, 0, 1);
    chk("flush_valid", {31'h0, dVALID}, 32'h0);
    chk("flush_rdy", {31'h0, iwb_rdy_o}, 32'h1);
    cyc(1, 0, 32'h0, 1, 0, 0);
    chk("flush_empty", dINST, NOP);
    cyc(1, 1, 32'h20208000, 1, 0, 0);
    chk("flush_immv", dSIMM, 32'hFFFF8000);

    // Branch wins over stall: the next cycle is ordinary RUN.
    cyc(1, 0, 32'h0, 1, 1, 1);
    cyc(1, 1, 32'h12345678, 1, 0, 0);
    chk("br_beats_stall", dINST, 32'h12345678);

    // Reset during BSF_HOLD with one word buffered.
    cyc(1, 1, 32'h90000001, 0, 0, 0);
    cyc(1, 0, 32'h0, 1, 1, 0);
    cyc(0, 1, 32'h90000002, 1, 1, 1);
    chk("rst_hold_inst", dINST, NOP);
    chk("rst_hold_rdy", {31'h0, iwb_rdy_o}, 32'h1);
    cyc(1, 0, 32'h0, 1, 0, 0);
    chk("rst_hold_empty", {31'h0, dVALID}, 32'h0);
    chk("rst_hold_run", dINST, NOP);

    cyc(1, 0, 32'h0, 0, 0, 0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
